// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core's
// memory stage and a multi-cycle backing memory (req/ack), with hit/miss counters.
//
// state   | meaning
// IDLE    | serve read hits combinationally, start misses and stores
// RD_MISS | read request outstanding, fill line on mem_ack
// WR_THRU | store request outstanding, replayed store suppressed after mem_ack
module dcache_dm_wt #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             Stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_MISS = 2'd1;
  localparam logic [1:0] WR_THRU = 2'd2;

  logic [1:0]            state;
  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];
  logic                  wr_done;
  logic                  fill_done;

  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      tag;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic                  is_idle;
  logic                  wr_start;
  logic                  rd_req;
  logic                  rd_hit;
  logic                  rd_miss;
  logic                  unused_byte_bits;

  assign idx      = Addr[INDEX_BITS+1:2];
  assign tag      = Addr[31:INDEX_BITS+2];
  assign fill_idx = mem_addr[INDEX_BITS+1:2];
  assign fill_tag = mem_addr[31:INDEX_BITS+2];
  assign hit      = valid[idx] && (tag_mem[idx] == tag);

  assign unused_byte_bits = ^{Addr[1:0], mem_addr[1:0]};

  // A store replayed in the cycle right after its ack must not go out again.
  assign is_idle  = (state == IDLE);
  assign wr_start = !Reset && is_idle && MemWrite && !wr_done;
  assign rd_req   = !Reset && is_idle && MemRead && !MemWrite;
  assign rd_hit   = rd_req && hit;
  assign rd_miss  = rd_req && !hit;

  always_comb begin
    Stall    = !Reset && (!is_idle || wr_start || rd_miss);
    ReadData = rd_hit ? data_mem[idx] : 32'h0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      valid      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      wr_done    <= 1'b0;
      fill_done  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          wr_done   <= 1'b0;
          fill_done <= 1'b0;
          if (wr_start) begin
            state     <= WR_THRU;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {Addr[31:2], 2'b00};
            mem_wdata <= WriteData;
          end else if (rd_miss) begin
            state    <= RD_MISS;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {Addr[31:2], 2'b00};
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
          end else if (rd_hit && !fill_done && (hit_count != '1)) begin
            // the lookup right after a fill is the same load, not a new hit
            hit_count <= hit_count + 1'b1;
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            state           <= IDLE;
            mem_req         <= 1'b0;
            valid[fill_idx] <= 1'b1;
            fill_done       <= 1'b1;
          end
        end
        WR_THRU: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            wr_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (wr_start && hit) begin
      data_mem[idx] <= WriteData;
    end else if (!Reset && (state == RD_MISS) && mem_ack) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Self-checking bench for dcache_dm_wt: table of core accesses with hand-derived
// expectations routed through a scoreboard queue, plus reset-abort and saturation sequences.
module tb_dcache_dm_wt;

  localparam int CW = 4;

  logic          CLK;
  logic          Reset;
  logic          MemRead;
  logic          MemWrite;
  logic [31:0]   Addr;
  logic [31:0]   WriteData;
  logic [31:0]   ReadData;
  logic          Stall;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  dcache_dm_wt #(.INDEX_BITS(4), .CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          exp_req;
    int          exp_we;
    int          exp_hits;
    int          exp_misses;
  } vec_t;

  vec_t        vecs[13];
  vec_t        sb_q[$];
  logic [31:0] bmem [logic [31:0]];
  int          n_pass = 0;
  int          n_total = 0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat, input logic [31:0] exp_rdata,
                              input int exp_stall, input int exp_req, input int exp_we,
                              input int exp_hits, input int exp_misses);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.lat = lat;
    v.exp_rdata = exp_rdata; v.exp_stall = exp_stall; v.exp_req = exp_req;
    v.exp_we = exp_we; v.exp_hits = exp_hits; v.exp_misses = exp_misses;
    return v;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {16'hF00D, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_cycle();
    MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
    @(posedge CLK); #1;
  endtask

  // Drives one core access, plays the backing memory, then checks against the scoreboard.
  task automatic run_op(input vec_t op, input string tag);
    int          stall_cyc, req_cyc, we_cyc, cyc;
    logic        hs_ok, done;
    logic [31:0] rd_seen, waddr;
    vec_t        exp;
    stall_cyc = 0; req_cyc = 0; we_cyc = 0; cyc = 0;
    hs_ok = 1'b1; done = 1'b0; rd_seen = 32'h0;
    sb_q.push_back(op);
    waddr = {op.addr[31:2], 2'b00};
    MemRead = op.rd; MemWrite = op.wr; Addr = op.addr; WriteData = op.wdata;
    while (!done && cyc < 64) begin
      @(negedge CLK);
      cyc++;
      if (mem_req) begin
        req_cyc++;
        if (mem_we) we_cyc++;
        if (mem_addr !== waddr || mem_we !== op.wr || (op.wr && mem_wdata !== op.wdata)) hs_ok = 1'b0;
        if (req_cyc == op.lat) begin
          mem_ack = 1'b1;
          if (mem_we) bmem[mem_addr] = mem_wdata;
          else mem_rdata = mem_read(mem_addr);
        end
      end
      if (Stall) stall_cyc++;
      else begin
        done = 1'b1;
        rd_seen = ReadData;
      end
      @(posedge CLK); #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
    @(negedge CLK);
    if (!done) begin
      n_total++;
      $display("FAIL %s timeout: Stall never released within %0d cycles", tag, cyc);
    end
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL %s scoreboard: queue empty", tag);
    end else begin
      exp = sb_q.pop_front();
      check({tag, " rdata"}, rd_seen, exp.exp_rdata);
      check({tag, " stall_cycles"}, stall_cyc, exp.exp_stall);
      check({tag, " req_cycles"}, req_cyc, exp.exp_req);
      check({tag, " we_cycles"}, we_cyc, exp.exp_we);
      check({tag, " handshake_stable"}, {31'b0, hs_ok}, 32'h1);
      check({tag, " idle_mem_req"}, {31'b0, mem_req}, 32'h0);
      check({tag, " idle_stall"}, {31'b0, Stall}, 32'h0);
      check({tag, " idle_rdata"}, ReadData, 32'h0);
      check({tag, " hit_count"}, {28'b0, hit_count}, exp.exp_hits);
      check({tag, " miss_count"}, {28'b0, miss_count}, exp.exp_misses);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    vec_t v;
    Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    bmem[32'h0000_0040] = 32'hDEAD_BEEF;
    bmem[32'h0000_0440] = 32'hCAFE_0440;

    //          rd    wr    addr          wdata         lat rdata        stl req we  h  m
    vecs[0]  = mk(1'b1, 1'b0, 32'h0000_0040, 32'h0,         3, 32'hDEAD_BEEF, 4, 3, 0, 0, 1);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0000_0040, 32'h0,         3, 32'hDEAD_BEEF, 0, 0, 0, 1, 1);
    vecs[2]  = mk(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 2, 32'h0,         3, 2, 2, 1, 1);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0000_0040, 32'h0,         3, 32'h1234_5678, 0, 0, 0, 2, 1);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0000_0440, 32'h0,         2, 32'hCAFE_0440, 3, 2, 0, 2, 2);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0000_0040, 32'h0,         1, 32'h1234_5678, 2, 1, 0, 2, 3);
    vecs[6]  = mk(1'b0, 1'b1, 32'h0000_0080, 32'hAAAA_5555, 1, 32'h0,         2, 1, 1, 2, 3);
    vecs[7]  = mk(1'b1, 1'b0, 32'h0000_0080, 32'h0,         2, 32'hAAAA_5555, 3, 2, 0, 2, 4);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0000_0080, 32'h0,         2, 32'hAAAA_5555, 0, 0, 0, 3, 4);
    vecs[9]  = mk(1'b1, 1'b0, 32'h0000_004E, 32'h0,         4, 32'hF00D_004C, 5, 4, 0, 3, 5);
    vecs[10] = mk(1'b1, 1'b0, 32'h0000_004C, 32'h0,         2, 32'hF00D_004C, 0, 0, 0, 4, 5);
    vecs[11] = mk(1'b1, 1'b1, 32'h0000_004C, 32'h1111_2222, 1, 32'h0,         2, 1, 1, 4, 5);
    vecs[12] = mk(1'b1, 1'b0, 32'h0000_004C, 32'h0,         3, 32'h1111_2222, 0, 0, 0, 5, 5);

    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    check("reset stall", {31'b0, Stall}, 32'h0);
    check("reset mem_req", {31'b0, mem_req}, 32'h0);
    check("reset mem_we", {31'b0, mem_we}, 32'h0);
    check("reset rdata", ReadData, 32'h0);
    check("reset hits", {28'b0, hit_count}, 32'h0);
    check("reset misses", {28'b0, miss_count}, 32'h0);
    @(posedge CLK); #1;

    for (int i = 0; i < 13; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset while a read miss is outstanding, then a stray ack in IDLE.
    MemRead = 1'b1; Addr = 32'h0000_0440;
    begin
      int reqs;
      int cyc;
      reqs = 0; cyc = 0;
      while (reqs < 2 && cyc < 20) begin
        @(negedge CLK);
        cyc++;
        if (mem_req) reqs++;
        if (reqs < 2) begin @(posedge CLK); #1; end
      end
      check("abort reached RD_MISS", reqs, 2);
    end
    Reset = 1'b1; MemRead = 1'b0; Addr = 32'h0;
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(negedge CLK);
    check("abort mem_req", {31'b0, mem_req}, 32'h0);
    check("abort stall", {31'b0, Stall}, 32'h0);
    check("abort hits", {28'b0, hit_count}, 32'h0);
    check("abort misses", {28'b0, miss_count}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    @(negedge CLK);
    check("late ack mem_req", {31'b0, mem_req}, 32'h0);
    check("late ack stall", {31'b0, Stall}, 32'h0);
    @(posedge CLK); #1;

    v = mk(1'b1, 1'b0, 32'h0000_0440, 32'h0, 2, 32'hCAFE_0440, 3, 2, 0, 0, 1);
    run_op(v, "post_reset_miss");

    // 16 hits against a 4-bit counter: must stick at 15.
    for (int i = 0; i < 16; i++) begin
      v = mk(1'b1, 1'b0, 32'h0000_0440, 32'h0, 1, 32'hCAFE_0440, 0, 0, 0,
             (i + 1 > 15) ? 15 : i + 1, 1);
      run_op(v, $sformatf("sat%0d", i));
    end

    idle_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dcache_dm_wt.md
Name: dcache_dm_wt

Overview:
Direct-mapped, write-through, no-write-allocate data cache placed directly downstream of the pipelined core's memory-stage port (ALUResult_M / WriteData / MemWrite).
- Serves read hits combinationally, in the same cycle.
- Misses and all writes go to a multi-cycle backing data memory through a req/ack handshake; the core is stalled meanwhile.
- Hit and miss counters are included for performance evaluation alongside the branch predictor.

Parameters:
INDEX_BITS, 4, log2 of number of one-word lines (16 lines).
CNT_W, 32, width of hit/miss counters (saturating).

Ports:
CLK  input  1  clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
MemRead  input  1  core load request (MemtoReg_M).
MemWrite  input  1  core store request (MemWrite_M).
Addr  input  32  byte address from ALUResult_M; bits [1:0] ignored.
WriteData  input  32  store data.
ReadData  output  32  load data to core (feeds ReadData_W register).
Stall  output  1  freeze F/D/E/M pipeline registers while high.
mem_req  output  1  backing-memory request.
mem_we  output  1  1 = write, 0 = read; valid while mem_req high.
mem_addr  output  32  word-aligned address ({Addr[31:2],2'b00}).
mem_wdata  output  32  store data to backing memory.
mem_rdata  input  32  backing-memory read data; valid when mem_ack high.
mem_ack  input  1  one-cycle completion pulse.
hit_count  output  CNT_W  read hits since reset.
miss_count  output  CNT_W  read misses since reset.

Behaviour:
- Storage: 2^INDEX_BITS entries, each holding valid, tag, and data[31:0].
  - index = Addr[INDEX_BITS+1:2]; tag = Addr[31:INDEX_BITS+2].
  - hit = valid[index] && tag[index]==tag.
- Reset (synchronous): all valid bits cleared; FSM to IDLE; counters 0; mem_req=0, mem_we=0, Stall=0, ReadData=0. Reset asserted mid-transaction aborts it: mem_req low from the next cycle; a late mem_ack in IDLE is ignored.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - MemWrite=1 (takes priority over MemRead if both are high):
    - Stall=1; go WR_THRU.
    - On a hit, the line data is updated with WriteData at this edge. A miss does not allocate.
  - MemRead=1, hit:
    - ReadData=data[index] combinationally; Stall=0.
    - hit_count+1 at the edge.
  - MemRead=1, miss:
    - Stall=1; go RD_MISS.
    - miss_count+1 at this edge only, counted once per miss.
  - No request: ReadData=0, Stall=0.
- RD_MISS:
  - mem_req=1, mem_we=0, mem_addr held; Stall=1.
  - On mem_ack: fill line (valid=1, tag, data=mem_rdata); go IDLE.
  - The core's held request then hits in IDLE. Miss penalty = memory latency + 1 cycle; the re-lookup does not increment hit_count.
- WR_THRU:
  - mem_req=1, mem_we=1, mem_addr/mem_wdata held; Stall=1.
  - On mem_ack: go IDLE, with Stall=0 in that following IDLE cycle.
  - The replayed store in IDLE must not re-issue. A one-bit done flag, set on ack and cleared when the request changes or is absent, suppresses the repeat.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata are registered outputs and stable from assertion until the cycle after mem_ack.
  - mem_req is never high in IDLE.
- Counters saturate at all-ones.
- Replacement: a fill overwrites the indexed line unconditionally. Conflicting addresses with the same index evict each other.
- mem_ack arriving in the same cycle mem_req first rises is legal; the state leaves on that edge.

Test Plan:
- Cold read: Reset, then MemRead with Addr=0x0000_0040; mem_ack after 3 cycles with mem_rdata=0xDEAD_BEEF -> Stall high 4 cycles, mem_req high 3, ReadData=0xDEAD_BEEF; miss_count=1, hit_count=0.
- Repeat read of 0x40 -> Stall=0 same cycle, ReadData=0xDEAD_BEEF, hit_count=1, no mem_req.
- Store 0x1234_5678 to 0x40 (hit) -> mem_req=1, mem_we=1, mem_wdata=0x1234_5678 until ack; exactly one memory write; subsequent read of 0x40 hits with 0x1234_5678.
- Conflict: read 0x40 then 0x440 (same index 0, different tag) -> second is a miss and fills; re-read of 0x40 misses again; miss_count increments each time.
- Store miss to 0x80, then read 0x80 -> the store does not allocate; the read misses and fetches from memory.
- Reset asserted during RD_MISS before ack -> next cycle mem_req=0, Stall=0, counters 0; a subsequent ack is ignored; a read of the same address misses again.
